// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: controller state
// encodings and register-address constants.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a register
// that the load currently in EX is about to write.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  mem_read,
    output logic                  load_use
);

    // x0 is never really written, so a load targeting it cannot create a hazard
    assign load_use = mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Drains the pipe
// after reset, inserts load-use bubbles, flushes on taken branches and
// freezes on multi-cycle data-memory accesses (halting on timeout).
// Optional macro HAZ_PERF_EN adds the Stall_Cycles / Flush_Count counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS1,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS2,
    input  logic [REG_ADDR_W-1:0] ID_EX_RD,
    input  logic                  ID_EX_MemRead,
    input  logic                  Branch_Taken,
    input  logic                  EX_MEM_MemAccess,
    input  logic                  Mem_Ready,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  EX_MEM_Write,
    output logic                  MEM_WB_Bubble,
    output logic                  Mem_Timeout,
    output logic [1:0]            Ctrl_State
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]      Stall_Cycles,
    output logic [CNT_W-1:0]      Flush_Count
`endif
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = '1;

    ctrl_state_t        state_q, state_nx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               timeout_q;
    logic               load_use;
    logic               mem_stall;
    logic               act;    // branch / load-use decode is live this cycle

    assign mem_stall   = EX_MEM_MemAccess && !Mem_Ready;
    assign Ctrl_State  = state_q;
    assign Mem_Timeout = timeout_q;

    load_use_detect u_load_use (
        .rs1      (IF_ID_RS1),
        .rs2      (IF_ID_RS2),
        .rd       (ID_EX_RD),
        .mem_read (ID_EX_MemRead),
        .load_use (load_use)
    );

    // next state and stage-register controls; default is a full freeze
    always_comb begin
        state_nx      = state_q;
        act           = 1'b0;
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b1;
        case (state_q)
            ST_DRAIN: begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Flush  = 1'b1;
                EX_MEM_Write = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall) state_nx = ST_MEM_WAIT;
                else           act      = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (!Mem_Ready) begin
                    if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT)) state_nx = ST_HALT;
                end else begin
                    // release cycle: the branch/load held during the freeze now acts
                    act      = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            default: ;  // HALT stays frozen until reset
        endcase
        if (act) begin
            PC_Write      = 1'b1;
            IF_ID_Write   = 1'b1;
            EX_MEM_Write  = 1'b1;
            MEM_WB_Bubble = 1'b0;
            // a taken branch squashes the dependent instruction, so it wins over load-use
            if (Branch_Taken) begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end else if (load_use) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
        end
    end

    // state register, drain/wait counters and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_DRAIN;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            if (state_q == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
            case (state_q)
                ST_RUN:      if (mem_stall) wait_cnt <= WAIT_W'(1);
                ST_MEM_WAIT: begin
                    if (Mem_Ready)                  wait_cnt <= '0;
                    else if (wait_cnt != WAIT_MAX)  wait_cnt <= wait_cnt + 1'b1;
                end
                default: ;
            endcase
            if (state_nx == ST_HALT) timeout_q <= 1'b1;
        end
    end

`ifdef HAZ_PERF_EN
    // free-running perf counters, wrap at 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Stall_Cycles <= '0;
            Flush_Count  <= '0;
        end else begin
            if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !PC_Write)
                Stall_Cycles <= Stall_Cycles + 1'b1;
            if (act && Branch_Taken)
                Flush_Count <= Flush_Count + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table for the RUN
// decode, directed multi-cycle sequences, and randomized traffic compared
// against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int DRAIN = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       mr, bt, acc, rdy;
    } in_t;

    typedef struct packed {
        logic       pcw, ifw, ifl, idl, exw, bub, tmo;
        logic [1:0] st;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       mr, bt, acc, rdy;
    logic       pcw, ifw, ifl, idl, exw, bub, tmo;
    logic [1:0] st;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int errs   = 0;
    int checks = 0;

    // behavioural model state
    int m_age;      // cycles spent draining since reset release
    bit m_wait;     // memory access outstanding
    int m_mw;       // not-ready cycles seen in the current wait
    bit m_halt, m_tmo;
    int m_stalls, m_flushes;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_RS1        (rs1),
        .IF_ID_RS2        (rs2),
        .ID_EX_RD         (rd),
        .ID_EX_MemRead    (mr),
        .Branch_Taken     (bt),
        .EX_MEM_MemAccess (acc),
        .Mem_Ready        (rdy),
        .PC_Write         (pcw),
        .IF_ID_Write      (ifw),
        .IF_ID_Flush      (ifl),
        .ID_EX_Flush      (idl),
        .EX_MEM_Write     (exw),
        .MEM_WB_Bubble    (bub),
        .Mem_Timeout      (tmo),
        .Ctrl_State       (st)
`ifdef HAZ_PERF_EN
        ,
        .Stall_Cycles     (stall_cycles),
        .Flush_Count      (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic in_t mk_in(input int a, input int b, input int d, input bit m,
                                  input bit br, input bit ac, input bit ry);
        in_t i;
        i.rs1 = 5'(a); i.rs2 = 5'(b); i.rd = 5'(d);
        i.mr = m; i.bt = br; i.acc = ac; i.rdy = ry;
        return i;
    endfunction

    function automatic out_t mk_run(input bit p, input bit f, input bit fl, input bit dl,
                                    input bit e, input bit bb);
        out_t o;
        o = '0;
        o.pcw = p; o.ifw = f; o.ifl = fl; o.idl = dl; o.exw = e; o.bub = bb;
        o.st = 2'd1;
        return o;
    endfunction

    function automatic out_t dut_now();
        return out_t'({pcw, ifw, ifl, idl, exw, bub, tmo, st});
    endfunction

    task automatic model_reset();
        m_age = 0; m_wait = 0; m_mw = 0; m_halt = 0; m_tmo = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // expected outputs for this cycle, from the model's notion of where the pipe is
    function automatic out_t model_out(input in_t i);
        out_t o;
        bit   lu;
        lu = i.mr && (i.rd != 0) && ((i.rd == i.rs1) || (i.rd == i.rs2));
        o = '0;
        o.tmo = m_tmo;
        if (m_age < DRAIN) begin
            o.ifl = 1; o.idl = 1; o.exw = 1; o.bub = 1; o.st = 2'd0;
        end else if (m_halt) begin
            o.bub = 1; o.st = 2'd3;
        end else begin
            o.st = m_wait ? 2'd2 : 2'd1;
            if (!i.rdy && (m_wait || i.acc)) begin
                o.bub = 1;
            end else begin
                o.pcw = 1; o.ifw = 1; o.exw = 1;
                if (i.bt) begin
                    o.ifl = 1; o.idl = 1;
                end else if (lu) begin
                    o.pcw = 0; o.ifw = 0; o.idl = 1;
                end
            end
        end
        return o;
    endfunction

    task automatic model_step(input in_t i, input out_t o);
        if (m_age < DRAIN) begin
            m_age++;
        end else if (!m_halt) begin
            if (!o.pcw) m_stalls++;
            if (o.ifl)  m_flushes++;
            if (m_wait) begin
                if (i.rdy) m_wait = 0;
                else begin
                    m_mw++;
                    if (m_mw == TMO) begin m_halt = 1; m_tmo = 1; end
                end
            end else if (i.acc && !i.rdy) begin
                m_wait = 1; m_mw = 0;
            end
        end
    endtask

    // one clock: drive at posedge+1, compare at negedge, advance model
    task automatic step(input in_t i, output out_t got);
        out_t exp;
        rs1 = i.rs1; rs2 = i.rs2; rd = i.rd;
        mr = i.mr; bt = i.bt; acc = i.acc; rdy = i.rdy;
        @(negedge clk);
        exp = model_out(i);
        got = dut_now();
        chk("model", 32'(got), 32'(exp));
`ifdef HAZ_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(m_stalls));
        chk("flush_count", flush_count, 32'(m_flushes));
`endif
        model_step(i, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_t d;
        d = '0;
        d.ifl = 1; d.idl = 1; d.exw = 1; d.bub = 1; d.st = 2'd0;
        reset = 1'b1;
        #1;
        chk("reset_outputs", 32'(dut_now()), 32'(d));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        vec_t vecs[9];
        out_t got;
        in_t  idle;
        int   n_drain;

        vecs[0] = '{"idle",        mk_in(0, 0, 0, 0, 0, 0, 1), mk_run(1, 1, 0, 0, 1, 0)};
        vecs[1] = '{"lu_rs2",      mk_in(1, 5, 5, 1, 0, 0, 1), mk_run(0, 0, 0, 1, 1, 0)};
        vecs[2] = '{"lu_rd_x0",    mk_in(0, 5, 0, 1, 0, 0, 1), mk_run(1, 1, 0, 0, 1, 0)};
        vecs[3] = '{"lu_rs1",      mk_in(7, 2, 7, 1, 0, 0, 1), mk_run(0, 0, 0, 1, 1, 0)};
        vecs[4] = '{"no_load",     mk_in(7, 2, 7, 0, 0, 0, 1), mk_run(1, 1, 0, 0, 1, 0)};
        vecs[5] = '{"br_over_lu",  mk_in(1, 5, 5, 1, 1, 0, 1), mk_run(1, 1, 1, 1, 1, 0)};
        vecs[6] = '{"br_only",     mk_in(3, 4, 9, 0, 1, 0, 1), mk_run(1, 1, 1, 1, 1, 0)};
        vecs[7] = '{"acc_ready",   mk_in(3, 4, 9, 1, 0, 1, 1), mk_run(1, 1, 0, 0, 1, 0)};
        vecs[8] = '{"acc_rdy_lu",  mk_in(9, 4, 9, 1, 0, 1, 1), mk_run(0, 0, 0, 1, 1, 0)};

        idle  = mk_in(0, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; mr = 0; bt = 0; acc = 0; rdy = 1;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        do_reset();

        // drain after reset, then RUN
        n_drain = 0;
        for (int c = 0; c < DRAIN; c++) begin
            step(idle, got);
            if (!got.pcw && got.ifl && got.idl && got.bub) n_drain++;
        end
        chk("drain_len", 32'(n_drain), 32'(DRAIN));
        step(idle, got);
        chk("run_pcw", 32'(got.pcw), 32'd1);
        chk("run_state", 32'(got.st), 32'd1);

        // RUN decode table
        foreach (vecs[k]) begin
            step(vecs[k].i, got);
            chk(vecs[k].name, 32'(got), 32'(vecs[k].o));
        end

        // memory freeze: ready low 3 cycles, then high
        step(mk_in(0, 0, 0, 0, 0, 1, 0), got);
        chk("mw_c1_frz", 32'({got.pcw, got.exw, got.bub, got.st}), 32'b00101);
        step(mk_in(0, 0, 0, 0, 0, 1, 0), got);
        chk("mw_c2_frz", 32'({got.pcw, got.exw, got.bub, got.st}), 32'b00110);
        step(mk_in(0, 0, 0, 0, 0, 1, 0), got);
        chk("mw_c3_frz", 32'({got.pcw, got.exw, got.bub, got.st}), 32'b00110);
        step(mk_in(0, 0, 0, 0, 0, 1, 1), got);
        chk("mw_release", 32'({got.pcw, got.exw, got.bub, got.st}), 32'b11010);
        step(idle, got);
        chk("mw_back_run", 32'(got.st), 32'd1);

        // branch held during freeze acts only on release
        step(mk_in(0, 0, 0, 0, 1, 1, 0), got);
        chk("br_frz_run", 32'({got.ifl, got.idl}), 32'b00);
        step(mk_in(0, 0, 0, 0, 1, 1, 0), got);
        chk("br_frz_wait", 32'({got.ifl, got.idl}), 32'b00);
        step(mk_in(0, 0, 0, 0, 1, 1, 1), got);
        chk("br_release", 32'({got.pcw, got.ifl, got.idl}), 32'b111);

        // load-use held during freeze stalls on release
        step(mk_in(6, 0, 6, 1, 0, 1, 0), got);
        step(mk_in(6, 0, 6, 1, 0, 1, 1), got);
        chk("lu_release", 32'({got.pcw, got.ifw, got.idl, got.st}), 32'b00110);

        // timeout: TMO not-ready MEM_WAIT cycles then HALT
        step(mk_in(0, 0, 0, 0, 0, 1, 0), got);
        for (int c = 0; c < TMO; c++) begin
            step(mk_in(0, 0, 0, 0, 0, 1, 0), got);
            chk("tmo_waiting", 32'({got.tmo, got.st}), 32'b010);
        end
        step(mk_in(0, 0, 0, 0, 0, 1, 0), got);
        chk("halt_entry", 32'({got.pcw, got.bub, got.tmo, got.st}), 32'b01111);
        step(mk_in(0, 0, 0, 0, 1, 1, 1), got);
        chk("halt_sticky", 32'({got.pcw, got.ifl, got.tmo, got.st}), 32'b00111);
        do_reset();
        step(idle, got);
        chk("post_halt_drain", 32'({got.tmo, got.st}), 32'b000);

        // randomized traffic vs model, with occasional resets
        for (int n = 0; n < 600; n++) begin
            in_t r;
            int  rdy_pct;
            rdy_pct = (n < 300) ? 70 : 20;
            r.rs1 = 5'($urandom_range(0, 3));
            r.rs2 = 5'($urandom_range(0, 3));
            r.rd  = 5'($urandom_range(0, 3));
            r.mr  = ($urandom_range(0, 1) == 1);
            r.bt  = ($urandom_range(0, 3) == 0);
            r.acc = ($urandom_range(0, 1) == 1);
            r.rdy = ($urandom_range(0, 99) < rdy_pct);
            if ((m_halt && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0))
                do_reset();
            else
                step(r, got);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
